// File: rtl/sbp_stage_mem_arbiter_pkg.sv
// Shared widths and types for the stage-memory arbiter slice.
package sbp_pkg;

  localparam int unsigned AddrBitsDef  = 11;
  localparam int unsigned DataBitsDef  = 64;
  localparam int unsigned FifoDepthDef = 4;

  typedef logic [AddrBitsDef-1:0] mem_addr_t;
  typedef logic [DataBitsDef-1:0] mem_word_t;

  function automatic int unsigned cnt_bits(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sbp_stage_mem_arbiter_if.sv
// Lookup, update and memory-side signals of the stage-memory arbiter.
interface sbp_stage_mem_arbiter_if
  import sbp_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = AddrBitsDef,
  parameter int unsigned DATA_BITS  = DataBitsDef,
  parameter int unsigned FIFO_DEPTH = FifoDepthDef
) ();

  localparam int unsigned CntBits = cnt_bits(FIFO_DEPTH);

  logic                 lkp_read_i;
  logic [ADDR_BITS-1:0] lkp_addr_i;
  logic                 lkp_valid_o;
  logic [DATA_BITS-1:0] lkp_data_o;

  logic                 upd_valid_i;
  logic                 upd_ready_o;
  logic [ADDR_BITS-1:0] upd_addr_i;
  logic [DATA_BITS-1:0] upd_data_i;

  logic                 mem_en_o;
  logic                 mem_we_o;
  logic [ADDR_BITS-1:0] mem_addr_o;
  logic [DATA_BITS-1:0] mem_wdata_o;
  logic [DATA_BITS-1:0] mem_rdata_i;

  logic [CntBits-1:0]   pend_cnt_o;

  modport slave (
    input  lkp_read_i, lkp_addr_i, upd_valid_i, upd_addr_i, upd_data_i, mem_rdata_i,
    output lkp_valid_o, lkp_data_o, upd_ready_o, mem_en_o, mem_we_o, mem_addr_o,
           mem_wdata_o, pend_cnt_o
  );

  modport master (
    output lkp_read_i, lkp_addr_i, upd_valid_i, upd_addr_i, upd_data_i, mem_rdata_i,
    input  lkp_valid_o, lkp_data_o, upd_ready_o, mem_en_o, mem_we_o, mem_addr_o,
           mem_wdata_o, pend_cnt_o
  );

endinterface

// File: rtl/sbp_upd_fifo.sv
// Update write buffer; exposes every slot so the arbiter can forward pending data to reads.
module sbp_upd_fifo
  import sbp_pkg::*;
#(
  parameter int unsigned Depth    = FifoDepthDef,
  parameter int unsigned AddrBits = AddrBitsDef,
  parameter int unsigned DataBits = DataBitsDef,
  localparam int unsigned PtrBits = $clog2(Depth),
  localparam int unsigned CntBits = PtrBits + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push,
  input  logic [AddrBits-1:0]             push_addr,
  input  logic [DataBits-1:0]             push_data,
  input  logic                            pop,
  output logic [AddrBits-1:0]             head_addr,
  output logic [DataBits-1:0]             head_data,
  output logic                            empty,
  output logic [CntBits-1:0]              count,
  output logic [PtrBits-1:0]              head_ptr,
  output logic [Depth-1:0]                ent_valid,
  output logic [Depth-1:0][AddrBits-1:0]  ent_addr,
  output logic [Depth-1:0][DataBits-1:0]  ent_data
);

  logic [Depth-1:0][AddrBits-1:0] addr_mem;
  logic [Depth-1:0][DataBits-1:0] data_mem;
  logic [PtrBits-1:0]             wr_ptr_q, rd_ptr_q;
  logic [CntBits-1:0]             cnt_q;
  logic [PtrBits-1:0]             off;

  // Storage is deliberately not reset; pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= push_addr;
      data_mem[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_comb begin
    ent_valid = '0;
    off       = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      off          = PtrBits'(i) - rd_ptr_q;
      ent_valid[i] = {1'b0, off} < cnt_q;
    end
  end

  assign head_addr = addr_mem[rd_ptr_q];
  assign head_data = data_mem[rd_ptr_q];
  assign empty     = (cnt_q == '0);
  assign count     = cnt_q;
  assign head_ptr  = rd_ptr_q;
  assign ent_addr  = addr_mem;
  assign ent_data  = data_mem;

endmodule

// File: rtl/sbp_stage_mem_arbiter.sv
// Shares one single-port stage RAM between never-stalling lookups and buffered updates,
// forwarding pending update data to lookups that hit the buffer.
module sbp_stage_mem_arbiter
  import sbp_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = AddrBitsDef,
  parameter int unsigned DATA_BITS  = DataBitsDef,
  parameter int unsigned FIFO_DEPTH = FifoDepthDef
) (
  input logic                    clk,
  input logic                    rst,
  sbp_stage_mem_arbiter_if.slave bus
);

  localparam int unsigned PtrBits = $clog2(FIFO_DEPTH);
  localparam int unsigned CntBits = PtrBits + 1;

  logic                                  upd_accept, fifo_pop, fifo_empty;
  logic [ADDR_BITS-1:0]                  head_addr;
  logic [DATA_BITS-1:0]                  head_data;
  logic [CntBits-1:0]                    fifo_cnt;
  logic [PtrBits-1:0]                    head_ptr, idx;
  logic [FIFO_DEPTH-1:0]                 ent_valid;
  logic [FIFO_DEPTH-1:0][ADDR_BITS-1:0]  ent_addr;
  logic [FIFO_DEPTH-1:0][DATA_BITS-1:0]  ent_data;

  logic                 mem_en_d, mem_we_d;
  logic [ADDR_BITS-1:0] mem_addr_d, mem_addr_q;
  logic [DATA_BITS-1:0] mem_wdata_d, mem_wdata_q;

  logic                 fwd_hit, fwd_hit_q;
  logic [DATA_BITS-1:0] fwd_data, fwd_data_q;
  logic                 lkp_valid_q;
  logic [DATA_BITS-1:0] lkp_data_d, lkp_data_q;

  assign bus.upd_ready_o = (fifo_cnt < CntBits'(FIFO_DEPTH));
  assign upd_accept      = bus.upd_valid_i && bus.upd_ready_o;
  assign fifo_pop        = !rst && !bus.lkp_read_i && !fifo_empty;

  sbp_upd_fifo #(
    .Depth    (FIFO_DEPTH),
    .AddrBits (ADDR_BITS),
    .DataBits (DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (upd_accept),
    .push_addr (bus.upd_addr_i),
    .push_data (bus.upd_data_i),
    .pop       (fifo_pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .empty     (fifo_empty),
    .count     (fifo_cnt),
    .head_ptr  (head_ptr),
    .ent_valid (ent_valid),
    .ent_addr  (ent_addr),
    .ent_data  (ent_data)
  );

  // Reads always win the port; the buffer drains only on read-free cycles.
  always_comb begin
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (rst) begin
      mem_addr_d  = '0;
      mem_wdata_d = '0;
    end else if (bus.lkp_read_i) begin
      mem_en_d   = 1'b1;
      mem_addr_d = bus.lkp_addr_i;
    end else if (!fifo_empty) begin
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = head_addr;
      mem_wdata_d = head_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.mem_en_o    = mem_en_d;
  assign bus.mem_we_o    = mem_we_d;
  assign bus.mem_addr_o  = mem_addr_d;
  assign bus.mem_wdata_o = mem_wdata_d;

  // Walk oldest to youngest so the last match wins; same-cycle pushes are not yet visible.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
      idx = head_ptr + PtrBits'(k);
      if (ent_valid[idx] && (ent_addr[idx] == bus.lkp_addr_i)) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data[idx];
      end
    end
  end

  always_comb begin
    lkp_data_d = lkp_data_q;
    if (lkp_valid_q) lkp_data_d = fwd_hit_q ? fwd_data_q : bus.mem_rdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lkp_valid_q <= 1'b0;
      fwd_hit_q   <= 1'b0;
      fwd_data_q  <= '0;
      lkp_data_q  <= '0;
    end else begin
      lkp_valid_q <= bus.lkp_read_i;
      lkp_data_q  <= lkp_data_d;
      if (bus.lkp_read_i) begin
        fwd_hit_q  <= fwd_hit;
        fwd_data_q <= fwd_data;
      end
    end
  end

  assign bus.lkp_valid_o = lkp_valid_q;
  assign bus.lkp_data_o  = lkp_data_d;
  assign bus.pend_cnt_o  = fifo_cnt;

endmodule

// File: doc/sbp_stage_mem_arbiter.md
SBP_STAGE_MEM_ARBITER -- requirements
Module: sbp_stage_mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_BITS, default 11, stage memory address width; DATA_BITS, default 64, memory word width; FIFO_DEPTH, default 4, update write-buffer depth (power of two, at least 2).
REQ-002 Clocking and reset SHALL be one clock and asynchronous active-high reset.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
REQ-003 Lookup port, from the lookup stage; it never stalls:
- lkp_read_i  in  1  read request this cycle.
- lkp_addr_i  in  ADDR_BITS  read address.
- lkp_valid_o  out  1  read data valid; lkp_read_i delayed 1 cycle.
- lkp_data_o  out  DATA_BITS  read data.
REQ-004 Update port, control-plane writes, valid/ready handshake:
- upd_valid_i  in  1  write request.
- upd_ready_o  out  1  write buffer can accept.
- upd_addr_i  in  ADDR_BITS  write address.
- upd_data_i  in  DATA_BITS  write data.
REQ-005 Memory port, one shared single-port synchronous RAM with 1-cycle read latency:
- mem_en_o  out  1  access enable.
- mem_we_o  out  1  write enable.
- mem_addr_o  out  ADDR_BITS  address.
- mem_wdata_o  out  DATA_BITS  write data.
- mem_rdata_i  in  DATA_BITS  read data, valid the cycle after the read.
REQ-006 Status output: pend_cnt_o  out  $clog2(FIFO_DEPTH)+1  number of buffered writes.

Function
REQ-007 An update SHALL be accepted on a cycle where upd_valid_i && upd_ready_o; accepted updates are pushed into a FIFO in arrival order.
REQ-008 upd_ready_o SHALL equal (pend_cnt_o < FIFO_DEPTH), registered count, with no combinational path from upd_valid_i.
REQ-009 Memory port priority, combinational per cycle:
- lkp_read_i=1: mem_en_o=1, mem_we_o=0, mem_addr_o=lkp_addr_i.
- otherwise, FIFO non-empty: drain the FIFO head; mem_en_o=1, mem_we_o=1, addr and data from the head; pop the head.
- otherwise: mem_en_o=0, mem_we_o=0; addr and data hold their last value.
REQ-010 Lookup reads SHALL never be delayed or dropped; updates wait indefinitely under back-to-back reads, and there is no starvation timeout.
REQ-011 lkp_valid_o SHALL be lkp_read_i registered; lkp_data_o SHALL be valid exactly 1 cycle after the read.
REQ-012 Forwarding: on a read, lkp_addr_i SHALL be compared against all valid FIFO entries.
- On a hit, the youngest matching entry's data is registered and presented on lkp_data_o in the next cycle.
- On a miss, lkp_data_o = mem_rdata_i.
REQ-013 An update accepted in the same cycle as a read to the same address SHALL NOT be forwarded to that read; the read returns the prior contents.
REQ-014 A write drained in cycle T SHALL be visible through memory to a read issued at cycle T+1 or later.
REQ-015 Simultaneous push and pop SHALL leave pend_cnt_o unchanged; read/write pointers wrap modulo FIFO_DEPTH.
REQ-016 When lkp_read_i=0, lkp_data_o SHALL hold its last value.

Reset
REQ-017 On rst, the following SHALL be cleared asynchronously: FIFO pointers, pend_cnt_o=0, lkp_valid_o=0, lkp_data_o=0, forward-hit register=0, mem_en_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
REQ-018 upd_ready_o SHALL be 1 from the first cycle after rst deasserts.
REQ-019 Reset mid-operation SHALL discard all buffered writes without writing memory; the FIFO entry storage need not be reset.

Structure
REQ-020 Package sbp_pkg SHALL hold the ADDR_BITS and DATA_BITS defaults and the typedefs mem_addr_t and mem_word_t.
REQ-021 One sub-module, sbp_upd_fifo, SHALL implement the FIFO.
- It exposes head, push/pop, count and per-entry valid/addr/data arrays for forwarding.
- Compare and priority logic stays in sbp_stage_mem_arbiter.

Verification
REQ-022 Idle drain: reset, push (0x005, 0xAA) with no reads -> mem_we_o=1, addr 0x005 one cycle after acceptance; pend_cnt_o returns to 0.
REQ-023 Read priority: lkp_read_i=1 for 10 cycles while pushing 3 updates -> mem_we_o=0 throughout; the writes drain on the 3 cycles after reads stop; pend_cnt_o peaks at 3.
REQ-024 Full back-pressure: continuous reads, push 5 updates with FIFO_DEPTH=4 -> upd_ready_o=0 after the 4th; the 5th is accepted only after the first drain.
REQ-025 Forwarding: push (0x010, 0x11) then (0x010, 0x22), hold them with reads, then read 0x010 -> lkp_data_o=0x22, not memory contents.
REQ-026 Same-cycle hazard: accept (0x020, 0x33) in the same cycle as a read of 0x020 where memory holds 0x44 -> lkp_data_o=0x44; a later read after drain returns 0x33.
REQ-027 Reset mid-operation: 3 pending updates, assert rst -> pend_cnt_o=0, no memory write occurs, and a subsequent read returns the old memory data.
